cp0_unit: RTL
=============

# cp0_unit

Coprocessor-0 block consuming the memory-stage outputs of the M pipeline register: exception code, victim PC and delay-slot flag. Holds SR, Cause, EPC and PrID. Decides each cycle whether an exception or interrupt is taken. When one is taken, it drives `exc_int`, the flush/redirect signal into every pipeline register and the PC. It also serves `mtc0`/`mfc0` accesses and `eret`.

## Interface
- `PRID`, default 32'h0000_2021, read-only value of register 15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_M`  in  32  address of the instruction in M (0 for a bubble).
- `valid_M`  in  1  M holds a real instruction, not a bubble.
- `afterJump_M`  in  1  M instruction sits in a branch delay slot.
- `exccode_M`  in  5 ([6:2])  pending exception code; 0 means none.
- `eret_M`  in  1  `eret` is in M.
- `hw_int`  in  6 ([7:2])  external interrupt lines, level-sensitive.
- `we`  in  1  `mtc0` is in M.
- `addr`  in  5  CP0 register number (rd field).
- `wdata`  in  32  `mtc0` data.
- `rdata`  out  32  `mfc0` read data (combinational).
- `epc`  out  32  current EPC, used as the `eret` target.
- `exc_int`  out  1  exception/interrupt taken this cycle (combinational).

## Operation
- SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0. Cause is read-only to `mtc0`.
- EPC (14): 32 bits, writable.
- PrID (15): constant `PRID`.
- Any other address reads 0, and writes to it are ignored.
- `int_req = |(hw_int & IM) & IE & !EXL & valid_M`.
- `exc_req = (exccode_M != 0) & !EXL`.
- `exc_int = int_req | exc_req`.
- Interrupt has priority over exception. The recorded ExcCode is 0 for an interrupt and `exccode_M` for an exception.
- On an edge with `exc_int` = 1:
  - EXL <= 1.
  - BD <= `afterJump_M`.
  - ExcCode <= code as above.
  - EPC <= `afterJump_M ? pc_M - 4 : pc_M`, 32-bit wrap-around.
- On an edge with `eret_M` = 1 and `exc_int` = 0: EXL <= 0.
- `mtc0` takes effect at the edge only when `exc_int` = 0. A same-cycle exception discards the write.
- IP <= `hw_int` every cycle, unconditionally, including during EXL.
- `rdata` returns pre-edge register contents. Same-cycle write and read returns the old value.
- Output reset values: SR=0, Cause=0, EPC=0, hence `epc`=0, `exc_int`=0 (IE=0 blocks interrupts), `rdata`=0 unless addr=15.

## Timing
- Single clock domain; all state updates on the rising `clk` edge.
- `exc_int` is combinational from registered state plus M-stage inputs. It is valid in the same cycle and must meet setup at every pipeline register and the PC mux.
- Registered effects become visible one cycle later; e.g. `mfc0` reads the new EPC in the cycle after the exception.
- Back-to-back exceptions: the second is masked by EXL=1 and never re-captures EPC or Cause.
- An interrupt arriving while `valid_M`=0 is held off until the first cycle with `valid_M`=1. Lines are level-sensitive, so no latching is needed.
- `eret` together with an illegal-state interrupt (EXL=0): the interrupt wins and EXL stays 1.
- Reset asserted mid-handler clears EXL and EPC immediately, asynchronously.

## Structure
- Shared package `cp0_pkg`:
  - register numbers `CP0_SR`=12, `CP0_CAUSE`=13, `CP0_EPC`=14, `CP0_PRID`=15;
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
  - handler entry `EXC_ENTRY`=32'h0000_4180.
- Single flat module; no natural sub-module. Request logic and register file share all state.

## Test plan
- Reset, then `mtc0` SR=32'h0000_FC01, then `hw_int`=6'b000100 with `valid_M`=1, `pc_M`=32'h3010 -> `exc_int`=1 that cycle. Next cycle: Cause=32'h0000_1000, EPC=32'h3010, SR=32'h0000_FC03.
- `exccode_M`=12 (Ov), `afterJump_M`=1, `pc_M`=32'h3020 -> `exc_int`=1. Next cycle: Cause[31]=1, Cause[6:2]=12, EPC=32'h301C.
- With EXL=1, `exccode_M`=4 -> `exc_int`=0 and Cause/EPC unchanged. Then `eret_M`=1 -> EXL=0 next cycle.
- Same cycle `we`=1, `addr`=14, `wdata`=32'hDEAD and `exccode_M`=10 -> write dropped, EPC=`pc_M`, ExcCode=10.
- IE=1, IM all set, `hw_int`=6'b1, `valid_M`=0 for 3 cycles then 1 -> `exc_int` rises only in the fourth cycle.
- Reset pulsed mid-cycle while EXL=1 -> SR, Cause and EPC read 0 immediately, before the next edge; `rdata` at addr 15 = `PRID`.

Source files
------------

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes and helpers
package cp0_pkg;

  localparam logic [4:0]  CP0_SR    = 5'd12;
  localparam logic [4:0]  CP0_CAUSE = 5'd13;
  localparam logic [4:0]  CP0_EPC   = 5'd14;
  localparam logic [4:0]  CP0_PRID  = 5'd15;

  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // A delay-slot victim restarts at its branch, one word earlier.
  function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic after_jump);
    return after_jump ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// rtl/cp0_unit_if.sv - M-stage and mtc0/mfc0 bus between pipeline and CP0
interface cp0_unit_if;
  logic [31:0] pc_M;
  logic        valid_M;
  logic        afterJump_M;
  logic [6:2]  exccode_M;
  logic        eret_M;
  logic [7:2]  hw_int;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] epc;
  logic        exc_int;

  modport master (
    output pc_M, valid_M, afterJump_M, exccode_M, eret_M, hw_int, we, addr, wdata,
    input  rdata, epc, exc_int
  );

  modport slave (
    input  pc_M, valid_M, afterJump_M, exccode_M, eret_M, hw_int, we, addr, wdata,
    output rdata, epc, exc_int
  );
endinterface

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - Coprocessor 0: SR/Cause/EPC/PrID and exception/interrupt decision
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_2021
) (
  input  logic       clk,
  input  logic       reset,
  cp0_unit_if.slave  bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        exc_int;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        unused_wdata;

  assign unused_wdata = ^{bus.wdata[31:16], bus.wdata[9:2]};

  assign int_req = (|(bus.hw_int & im_q)) & ie_q & ~exl_q & bus.valid_M;
  assign exc_req = (bus.exccode_M != 5'd0) & ~exl_q;
  assign exc_int = int_req | exc_req;

  assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};

  assign bus.exc_int = exc_int;
  assign bus.epc     = epc_q;

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      CP0_SR:    bus.rdata = sr_word;
      CP0_CAUSE: bus.rdata = cause_word;
      CP0_EPC:   bus.rdata = epc_q;
      CP0_PRID:  bus.rdata = PRID;
      default:   bus.rdata = 32'd0;
    endcase
  end

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    ip_d      = bus.hw_int;
    if (exc_int) begin
      // Taking the trap discards any same-cycle mtc0 or eret.
      exl_d     = 1'b1;
      bd_d      = bus.afterJump_M;
      exccode_d = int_req ? EXC_INT : bus.exccode_M;
      epc_d     = victim_epc(bus.pc_M, bus.afterJump_M);
    end else begin
      if (bus.we) begin
        case (bus.addr)
          CP0_SR: begin
            im_d  = bus.wdata[15:10];
            exl_d = bus.wdata[1];
            ie_d  = bus.wdata[0];
          end
          CP0_EPC: epc_d = bus.wdata;
          default: ;
        endcase
      end
      if (bus.eret_M) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q      <= 6'd0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= 6'd0;
      exccode_q <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

endmodule
